// File: rtl/mem_arbiter.sv
// Purpose : two-port arbiter sharing one single-port synchronous word memory
//           between instruction fetch (port 0) and load/store (port 1).
// Latency : grant in the request cycle; read data returns MEM_LAT cycles after grant.
// Backpressure: a port that is not granted holds its request stable until granted.
//
// Ports:
//   clk, reset                  clock and asynchronous active-high reset
//   req/we/addr/wdata{0,1}      request from fetch (0) and data (1) ports
//   gnt{0,1}                    request accepted this cycle (combinational)
//   rvalid/rdata{0,1}           read response routed back to the issuing port
//   mem_en/we/addr/wdata        drive to the shared memory
//   mem_rdata                   memory read data, MEM_LAT cycles after a read issue
//
// Build option: define ARB_RR_EN for round-robin conflict resolution;
// without it port 1 (data) always wins a conflict.

module mem_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // The response pipeline is sized to the memory latency; outside 1..4
    // the memory this block is paired with does not exist.
    if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
        $error("mem_arbiter: MEM_LAT must be in 1..4");
    end

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic conflict;
    logic sel0;
    logic sel1;

    assign conflict = req0 & req1;

`ifdef ARB_RR_EN
    // prio_ptr names the port that wins the next conflict. It only moves
    // on conflict cycles, so an uncontended port never disturbs fairness.
    logic prio_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_ptr <= 1'b0;
        end else if (conflict) begin
            prio_ptr <= ~prio_ptr;
        end
    end

    assign sel0 = ~conflict | ~prio_ptr;
    assign sel1 = ~conflict |  prio_ptr;
`else
    // Data accesses stall the pipeline harder than fetch, so port 1 wins.
    assign sel0 = ~req1;
    assign sel1 = 1'b1;
`endif

    // Grants are masked by reset so nothing reaches the memory while the
    // core is being reset, even though the grant path is combinational.
    assign gnt0 = ~reset & req0 & sel0;
    assign gnt1 = ~reset & req1 & sel1;

    // ------------------------------------------------------------------
    // Memory drive: mux from the granted port, zero when idle
    // ------------------------------------------------------------------
    always_comb begin
        mem_en    = gnt0 | gnt1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt1) begin
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end else if (gnt0) begin
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end
    end

    // ------------------------------------------------------------------
    // Response pipeline: one {valid, owner} entry pushed per cycle.
    // Stage 0 captures the grant of the current cycle, so the tail stage
    // lines up with mem_rdata exactly MEM_LAT cycles after the grant.
    // ------------------------------------------------------------------
    logic               push_vld;
    logic               push_own;
    logic [MEM_LAT-1:0] pipe_vld;
    logic [MEM_LAT-1:0] pipe_own;

    assign push_vld = (gnt0 & ~we0) | (gnt1 & ~we1);
    assign push_own = gnt1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_vld <= '0;
            pipe_own <= '0;
        end else begin
            pipe_vld[0] <= push_vld;
            pipe_own[0] <= push_own;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_own[i] <= pipe_own[i-1];
            end
        end
    end

    // rvalid comes straight from pipeline flops; rdata is gated so a port
    // never sees the other port's data or stale memory output.
    assign rvalid0 = pipe_vld[MEM_LAT-1] & ~pipe_own[MEM_LAT-1];
    assign rvalid1 = pipe_vld[MEM_LAT-1] &  pipe_own[MEM_LAT-1];
    assign rdata0  = rvalid0 ? mem_rdata : '0;
    assign rdata1  = rvalid1 ? mem_rdata : '0;

endmodule
